// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode field values, the squash word and the
// fetch-stage state encoding.
package cpu_pkg;

    typedef logic [0:5] opcode_t;

    localparam opcode_t OP_ALU   = 6'b101010;
    localparam opcode_t OP_LOAD  = 6'b100000;
    localparam opcode_t OP_STORE = 6'b100001;
    localparam opcode_t OP_BEZ   = 6'b100010;
    localparam opcode_t OP_BNEZ  = 6'b100011;
    localparam opcode_t OP_NOP   = 6'b111100;

    // Opcode occupies [0:5]; the remaining bits of a NOP are don't-care zeros.
    localparam logic [0:31] NOP_WORD = {OP_NOP, 26'b0};

    localparam logic [1:0] FETCH_BOOT = 2'd0;
    localparam logic [1:0] FETCH_RUN  = 2'd1;
    localparam logic [1:0] FETCH_HOLD = 2'd2;

    function automatic opcode_t opcode_of(input logic [0:31] instr);
        return instr[0:5];
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register that catches the memory word returning while
// decode is stalled, so it can be handed over once the stall clears.
module fetch_skid_buffer
    import cpu_pkg::*;
#(
    parameter int unsigned PC_WIDTH  = 32,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                drain,
    input  logic                flush,
    input  logic [0:31]         load_instr,
    input  logic [0:PC_WIDTH-1] load_pc,
    input  logic                load_valid,
    output logic [0:31]         skid_instr,
    output logic [0:PC_WIDTH-1] skid_pc,
    output logic                skid_valid
);

    // Flush and drain both empty the entry; an emptied entry reads as a NOP bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_instr <= NOP_INSTR;
            skid_pc    <= '0;
            skid_valid <= 1'b0;
        end else if (flush || drain) begin
            skid_instr <= NOP_INSTR;
            skid_pc    <= '0;
            skid_valid <= 1'b0;
        end else if (load) begin
            skid_instr <= load_instr;
            skid_pc    <= load_pc;
            skid_valid <= load_valid;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives a one-cycle-latency instruction memory and
// presents a registered instruction/PC pair to decode.
//
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   FETCH_BOOT | first fetch after reset/redirect, nothing returning yet
//   FETCH_RUN  | streaming one fetch per cycle, returning word goes to IF/ID
//   FETCH_HOLD | decode stalled, returned word parked in skid, fetch paused
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned         PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned         PC_INC    = 4,
    parameter logic [31:0]         NOP_INSTR = NOP_WORD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [0:15]         branch_target,
    output logic                imem_en,
    output logic [0:PC_WIDTH-1] imem_addr,
    input  logic [0:31]         imem_data,
    output logic [0:31]         instruction,
    output logic [0:PC_WIDTH-1] instr_pc,
    output logic                instr_valid
);

    localparam logic [0:PC_WIDTH-1] PC_STEP    = PC_WIDTH'(PC_INC);
    localparam logic [0:PC_WIDTH-1] ALIGN_MASK = ~PC_WIDTH'(3);

    logic [1:0]          state;
    logic [0:PC_WIDTH-1] pc;
    logic [0:PC_WIDTH-1] pc_seq;
    logic [0:PC_WIDTH-1] target_pc;
    logic                inflight;
    logic [0:PC_WIDTH-1] inflight_pc;

    logic                fetch_go;
    logic                run_adv;
    logic                enter_hold;
    logic                leave_hold;

    logic [0:31]         skid_instr;
    logic [0:PC_WIDTH-1] skid_pc;
    logic                skid_valid;

    assign pc_seq    = pc + PC_STEP;
    assign target_pc = PC_WIDTH'(branch_target) & ALIGN_MASK;

    always_comb begin
        fetch_go   = 1'b0;
        run_adv    = 1'b0;
        enter_hold = 1'b0;
        leave_hold = 1'b0;
        if (!branch_taken) begin
            case (state)
                FETCH_BOOT: fetch_go = 1'b1;
                FETCH_RUN: begin
                    if (stall) begin
                        enter_hold = 1'b1;
                    end else begin
                        fetch_go = 1'b1;
                        run_adv  = 1'b1;
                    end
                end
                FETCH_HOLD: begin
                    if (!stall) begin
                        fetch_go   = 1'b1;
                        leave_hold = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Gate with reset so the memory sees no read while the stage is held in reset.
    assign imem_en   = reset & fetch_go;
    assign imem_addr = pc;

    fetch_skid_buffer #(
        .PC_WIDTH  (PC_WIDTH),
        .NOP_INSTR (NOP_INSTR)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (enter_hold),
        .drain      (leave_hold),
        .flush      (branch_taken),
        .load_instr (imem_data),
        .load_pc    (inflight_pc),
        .load_valid (inflight),
        .skid_instr (skid_instr),
        .skid_pc    (skid_pc),
        .skid_valid (skid_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FETCH_BOOT;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (branch_taken) begin
            state       <= FETCH_BOOT;
            pc          <= target_pc;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            if (fetch_go) begin
                pc          <= pc_seq;
                inflight    <= 1'b1;
                inflight_pc <= pc;
            end else if (enter_hold) begin
                inflight <= 1'b0;
            end
            case (state)
                FETCH_BOOT: state <= FETCH_RUN;
                FETCH_RUN:  if (stall)  state <= FETCH_HOLD;
                FETCH_HOLD: if (!stall) state <= FETCH_RUN;
                default:    state <= FETCH_BOOT;
            endcase
        end
    end

    // IF/ID register: only registered sources, never imem_data combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction <= NOP_INSTR;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (branch_taken) begin
            instruction <= NOP_INSTR;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (run_adv && inflight) begin
            instruction <= imem_data;
            instr_pc    <= inflight_pc;
            instr_valid <= 1'b1;
        end else if (leave_hold) begin
            instruction <= skid_instr;
            instr_pc    <= skid_pc;
            instr_valid <= skid_valid;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a
// randomized stall/branch run checked against an in-order stream model.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'hF000_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [0:15] branch_target;
    logic        imem_en;
    logic [0:31] imem_addr;
    logic [0:31] imem_data;
    logic [0:31] instruction;
    logic [0:31] instr_pc;
    logic        instr_valid;

    logic        w_imem_en;
    logic [0:31] w_imem_addr;
    logic [0:31] w_imem_data;
    logic [0:31] w_instruction;
    logic [0:31] w_instr_pc;
    logic        w_instr_valid;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_consumed = 0;
    logic [31:0] exp_pc = 32'h0;

    instruction_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .instruction   (instruction),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_en       (w_imem_en),
        .imem_addr     (w_imem_addr),
        .imem_data     (w_imem_data),
        .instruction   (w_instruction),
        .instr_pc      (w_instr_pc),
        .instr_valid   (w_instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    // Synchronous instruction memories, one-cycle read latency.
    always @(posedge clk) if (imem_en) imem_data <= mem_word(imem_addr);
    always @(posedge clk) if (w_imem_en) w_imem_data <= mem_word(w_imem_addr);

    // Stream model: decode consumes the presented word whenever it is valid and
    // not stalled; consumed PCs must run sequentially from reset or the last
    // branch target, with the matching memory word, nothing lost or repeated.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                exp_pc = 32'h0;
            end else begin
                n_cmp++;
                if (!instr_valid && instruction !== NOP) begin
                    n_bad++;
                    $display("FAIL model_bubble_nop got=%h exp=%h", instruction, NOP);
                end
                if (branch_taken || (instr_valid && stall)) begin
                    n_cmp++;
                    if (imem_en !== 1'b0) begin
                        n_bad++;
                        $display("FAIL model_imem_en_idle got=%b exp=0", imem_en);
                    end
                end
                if (branch_taken) begin
                    exp_pc = {16'h0, branch_target} & ~32'h3;
                end else if (instr_valid && !stall) begin
                    n_cmp++;
                    if (instr_pc !== exp_pc || instruction !== mem_word(exp_pc)) begin
                        n_bad++;
                        $display("FAIL model_stream got pc=%h instr=%h exp pc=%h instr=%h",
                                 instr_pc, instruction, exp_pc, mem_word(exp_pc));
                    end
                    exp_pc = exp_pc + 32'd4;
                    n_consumed++;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        stall = 1'b0;
        branch_taken = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        logic [31:0] e;
        reset = 1'b0;
        tick();
        tick();
        n_cmp++; if (instruction !== NOP) begin n_bad++; $display("FAIL reset_instr got=%h exp=%h", instruction, NOP); end
        n_cmp++; if (instr_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc got=%h exp=0", instr_pc); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        n_cmp++; if (imem_en !== 1'b0) begin n_bad++; $display("FAIL reset_imem_en got=%b exp=0", imem_en); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_imem_addr got=%h exp=0", imem_addr); end
        n_cmp++; if (w_imem_addr !== 32'hFFFF_FFF8) begin n_bad++; $display("FAIL reset_wrap_addr got=%h exp=fffffff8", w_imem_addr); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (imem_en !== 1'b1) begin n_bad++; $display("FAIL boot_imem_en got=%b exp=1", imem_en); end
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) begin
                n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL boot_bubble got=%b exp=0", instr_valid); end
            end else begin
                e = 32'(4 * (k - 1));
                n_cmp++;
                if (instr_valid !== 1'b1 || instr_pc !== e || instruction !== mem_word(e)) begin
                    n_bad++;
                    $display("FAIL boot_seq k=%0d got v=%b pc=%h i=%h exp pc=%h i=%h",
                             k, instr_valid, instr_pc, instruction, e, mem_word(e));
                end
                e = 32'hFFFF_FFF8 + 32'(4 * (k - 1));
                n_cmp++;
                if (w_instr_valid !== 1'b1 || w_instr_pc !== e || w_instruction !== mem_word(e)) begin
                    n_bad++;
                    $display("FAIL wrap_seq k=%0d got v=%b pc=%h exp pc=%h", k, w_instr_valid, w_instr_pc, e);
                end
            end
        end
    endtask

    task automatic test_stall;
        logic [31:0] e;
        do_reset();
        repeat (3) tick();
        n_cmp++; if (instr_pc !== 32'h4) begin n_bad++; $display("FAIL stall_pre got=%h exp=4", instr_pc); end
        stall = 1'b1;
        #1;
        n_cmp++; if (imem_en !== 1'b0) begin n_bad++; $display("FAIL stall_imem_en got=%b exp=0", imem_en); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instruction !== mem_word(32'h4)) begin
                n_bad++;
                $display("FAIL stall_hold k=%0d got v=%b pc=%h i=%h exp pc=4", k, instr_valid, instr_pc, instruction);
            end
            n_cmp++;
            if (imem_en !== 1'b0 || imem_addr !== 32'hC) begin
                n_bad++;
                $display("FAIL stall_fetch k=%0d got en=%b addr=%h exp en=0 addr=c", k, imem_en, imem_addr);
            end
        end
        stall = 1'b0;
        #1;
        n_cmp++; if (imem_en !== 1'b1) begin n_bad++; $display("FAIL stall_release_en got=%b exp=1", imem_en); end
        for (int k = 0; k < 3; k++) begin
            tick();
            e = 32'h8 + 32'(4 * k);
            n_cmp++;
            if (instr_valid !== 1'b1 || instr_pc !== e || instruction !== mem_word(e)) begin
                n_bad++;
                $display("FAIL stall_resume k=%0d got pc=%h i=%h exp pc=%h", k, instr_pc, instruction, e);
            end
        end
    endtask

    task automatic test_branch;
        do_reset();
        repeat (4) tick();
        branch_taken = 1'b1;
        branch_target = 16'h0040;
        #1;
        n_cmp++; if (imem_en !== 1'b0) begin n_bad++; $display("FAIL branch_imem_en got=%b exp=0", imem_en); end
        tick();
        branch_taken = 1'b0;
        n_cmp++; if (imem_addr !== 32'h40) begin n_bad++; $display("FAIL branch_addr got=%h exp=40", imem_addr); end
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (instr_valid !== 1'b0 || instruction !== NOP) begin
                n_bad++;
                $display("FAIL branch_bubble k=%0d got v=%b i=%h exp v=0 i=%h", k, instr_valid, instruction, NOP);
            end
            tick();
        end
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instruction !== mem_word(32'h40)) begin n_bad++; $display("FAIL branch_first got pc=%h i=%h exp pc=40", instr_pc, instruction); end
        tick();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h44) begin n_bad++; $display("FAIL branch_second got pc=%h exp pc=44", instr_pc); end
    endtask

    task automatic test_branch_stall_hold;
        do_reset();
        repeat (3) tick();
        stall = 1'b1;
        tick();
        tick();
        branch_taken = 1'b1;
        branch_target = 16'h0100;
        tick();
        branch_taken = 1'b0;
        stall = 1'b0;
        n_cmp++; if (imem_addr !== 32'h100) begin n_bad++; $display("FAIL bhold_addr got=%h exp=100", imem_addr); end
        n_cmp++; if (instr_valid !== 1'b0 || instruction !== NOP) begin n_bad++; $display("FAIL bhold_bubble got v=%b i=%h exp v=0", instr_valid, instruction); end
        tick();
        tick();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin n_bad++; $display("FAIL bhold_target got v=%b pc=%h exp pc=100", instr_valid, instr_pc); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if (instr_pc === 32'h8 || instr_pc !== 32'h104 + 32'(4 * k)) begin
                n_bad++;
                $display("FAIL bhold_stream k=%0d got pc=%h exp pc=%h", k, instr_pc, 32'h104 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_target_align;
        branch_taken = 1'b1;
        branch_target = 16'h0043;
        tick();
        branch_taken = 1'b0;
        n_cmp++; if (imem_addr !== 32'h40) begin n_bad++; $display("FAIL align_addr got=%h exp=40", imem_addr); end
        tick();
        tick();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instruction !== mem_word(32'h40)) begin n_bad++; $display("FAIL align_first got pc=%h exp=40", instr_pc); end
    endtask

    task automatic test_reset_midstream;
        bit found = 1'b0;
        do_reset();
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (instr_valid === 1'b1 && instr_pc === 32'h20) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL midreset_reach got=timeout exp=pc 20");
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (instruction !== NOP || instr_pc !== 32'h0 || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_outputs got i=%h pc=%h v=%b exp i=%h pc=0 v=0", instruction, instr_pc, instr_valid, NOP);
        end
        n_cmp++; if (imem_en !== 1'b0 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL midreset_fetch got en=%b addr=%h exp en=0 addr=0", imem_en, imem_addr); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (imem_en !== 1'b1 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL midreset_refetch got en=%b addr=%h exp en=1 addr=0", imem_en, imem_addr); end
        tick();
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_bubble got=%b exp=0", instr_valid); end
        tick();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instruction !== mem_word(32'h0)) begin n_bad++; $display("FAIL midreset_first got pc=%h i=%h exp pc=0", instr_pc, instruction); end
    endtask

    task automatic test_random;
        int start;
        do_reset();
        start = n_consumed;
        for (int k = 0; k < 1500; k++) begin
            tick();
            if (branch_taken) begin
                branch_taken = 1'b0;
            end else begin
                branch_taken = ($urandom_range(0, 99) < 4);
                branch_target = 16'($urandom());
            end
            stall = ($urandom_range(0, 99) < 30);
        end
        tick();
        branch_taken = 1'b0;
        stall = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (n_consumed - start < 400) begin
            n_bad++;
            $display("FAIL random_throughput got=%0d exp>=400", n_consumed - start);
        end
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 16'h0;
        test_reset();
        test_stall();
        test_branch();
        test_branch_stall_hold();
        test_target_align();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
